// File: rtl/riscv_pkg.sv
// Shared RV32I definitions for the decode/issue slice: opcodes, NOP encoding,
// register-address width and the ID holding-register state type.
package riscv_pkg;

  localparam int REG_ADDR_W = 5;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } id_state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard check of the held instruction against the load last issued to EX.
// Purely combinational; the caller qualifies the result with ID occupancy.
module hazard_detect
  import riscv_pkg::*;
(
  input  logic [6:0]            opcode,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic                  last_load_v,
  input  logic [REG_ADDR_W-1:0] last_load_rd,
  output logic                  uses_rs1,
  output logic                  uses_rs2,
  output logic                  hazard
);

  assign uses_rs1 = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
  assign uses_rs2 = (opcode == OP_RTYPE) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

  // x0 is never a real producer, so a load to x0 must not stall.
  assign hazard = last_load_v && (last_load_rd != '0) &&
                  ((uses_rs1 && (rs1 == last_load_rd)) ||
                   (uses_rs2 && (rs2 == last_load_rd)));

endmodule

// File: rtl/decode_issue_ctrl.sv
// IF/ID holding register with load-use bubble insertion and valid/ready issue to EX.
// Optional STALL_CNT_EN adds a saturating stall_cycles counter output.
//
// state    | meaning
// ST_EMPTY | ID register holds NOP, nothing to issue
// ST_FULL  | ID register holds a fetched instruction awaiting issue
module decode_issue_ctrl
  import riscv_pkg::*;
#(
  parameter int               XLEN      = 32,
  parameter logic [XLEN-1:0]  NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [XLEN-1:0] if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic            if_ready,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc,
  output logic [4:0]      id_rs1,
  output logic [4:0]      id_rs2,
  output logic [4:0]      id_rd,
  output logic [6:0]      id_opcode,
  output logic            id_is_load
`ifdef STALL_CNT_EN
  ,
  output logic [31:0]     stall_cycles
`endif
);

  id_state_t             state_q, state_d;
  logic [XLEN-1:0]       instr_q, instr_d;
  logic [XLEN-1:0]       pc_q, pc_d;
  logic                  ll_v_q, ll_v_d;
  logic [REG_ADDR_W-1:0] ll_rd_q, ll_rd_d;

  logic full;
  logic hd_hazard;
  logic hazard;
  logic id_fire;
  logic if_fire;
  logic uses_rs1;
  logic uses_rs2;
  logic unused_uses;

  assign full       = (state_q == ST_FULL);
  assign id_instr   = instr_q;
  assign id_pc      = pc_q;
  assign id_rs1     = instr_q[19:15];
  assign id_rs2     = instr_q[24:20];
  assign id_rd      = instr_q[11:7];
  assign id_opcode  = instr_q[6:0];
  assign id_is_load = (id_opcode == OP_LOAD);

  hazard_detect u_hazard_detect (
    .opcode       (id_opcode),
    .rs1          (id_rs1),
    .rs2          (id_rs2),
    .last_load_v  (ll_v_q),
    .last_load_rd (ll_rd_q),
    .uses_rs1     (uses_rs1),
    .uses_rs2     (uses_rs2),
    .hazard       (hd_hazard)
  );

  assign unused_uses = uses_rs1 ^ uses_rs2;

  assign hazard   = full && hd_hazard;
  assign id_valid = full && !hazard;
  assign id_fire  = id_valid && ex_ready;
  assign if_ready = !rst && !flush && (!full || id_fire);
  assign if_fire  = if_valid && if_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      ll_v_q  <= 1'b0;
      ll_rd_q <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      ll_v_q  <= ll_v_d;
      ll_rd_q <= ll_rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    ll_v_d  = ll_v_q;
    ll_rd_d = ll_rd_q;
    if (flush) begin
      state_d = ST_EMPTY;
      instr_d = NOP_INSTR;
      ll_v_d  = 1'b0;
    end else begin
      if (if_fire) begin
        state_d = ST_FULL;
        instr_d = if_instr;
        pc_d    = if_pc;
      end else if (id_fire) begin
        state_d = ST_EMPTY;
        instr_d = NOP_INSTR;
      end
      // Tracker only advances with EX, so a stalled EX keeps the hazard alive.
      if (ex_ready) begin
        ll_v_d  = id_fire && id_is_load;
        ll_rd_d = id_rd;
      end
    end
  end

`ifdef STALL_CNT_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (hazard && (stall_q != 32'hFFFF_FFFF)) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Scoreboard bench for decode_issue_ctrl: the driver queues expected issues,
// a negedge monitor pops and compares on every EX handshake.
module tb_decode_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        flush;
  logic        ex_ready;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic [6:0]  id_opcode;
  logic        id_is_load;
`ifdef STALL_CNT_EN
  logic [31:0] stall_cycles;
`endif

  decode_issue_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_ready   (if_ready),
    .flush      (flush),
    .ex_ready   (ex_ready),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_pc      (id_pc),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_rd      (id_rd),
    .id_opcode  (id_opcode),
    .id_is_load (id_is_load)
`ifdef STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [31:0] ADDI1   = 32'h0010_0093;  // addi x1,x0,1
  localparam logic [31:0] ADDI2   = 32'h0020_8113;  // addi x2,x1,2
  localparam logic [31:0] ADDI3   = 32'h0031_0193;  // addi x3,x2,3
  localparam logic [31:0] LW_X5   = 32'h0000_A283;  // lw x5,0(x1)
  localparam logic [31:0] ADD_X5  = 32'h0022_8333;  // add x6,x5,x2
  localparam logic [31:0] LW_X0   = 32'h0000_A003;  // lw x0,0(x1)
  localparam logic [31:0] ADD_X0  = 32'h0020_0333;  // add x6,x0,x2
  localparam logic [31:0] LUI_X5  = 32'h0002_82B7;  // lui x5,0x28 (rs1 field = 5)
  localparam logic [31:0] SW_X5   = 32'h0051_2023;  // sw x5,0(x2)

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    int          cyc;
    logic [4:0]  rs1;
    logic [4:0]  rd;
    logic        is_load;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && !flush && id_valid && ex_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_issue: got instr %h expected none", id_instr);
      end else begin
        mon_e = sb.pop_front();
        chk("issue_instr", id_instr, mon_e.instr);
        chk("issue_pc", id_pc, mon_e.pc);
        chk("issue_cycle", 32'(cyc), 32'(mon_e.cyc));
        chk("issue_rs1", 32'(id_rs1), 32'(mon_e.rs1));
        chk("issue_rd", 32'(id_rd), 32'(mon_e.rd));
        chk("issue_is_load", 32'(id_is_load), 32'(mon_e.is_load));
      end
    end
  end

  // bub = hand-computed bubble cycles between accept and issue beyond the normal one.
  task automatic send(input logic [31:0] ins, input logic [31:0] pc, input logic [4:0] rs1,
                      input logic [4:0] rd, input logic ld, input int bub, input bit push,
                      output int acc);
    bit   ok = 1'b0;
    exp_t e;
    acc      = -1;
    if_valid = 1'b1;
    if_instr = ins;
    if_pc    = pc;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (if_ready) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: if_ready stayed 0 for instr %h", ins);
    end else begin
      acc = cyc;
      if (push) begin
        e.instr   = ins;
        e.pc      = pc;
        e.cyc     = cyc + 1 + bub;
        e.rs1     = rs1;
        e.rd      = rd;
        e.is_load = ld;
        sb.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    if_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2, acc;
    rst      = 1'b1;
    if_valid = 1'b0;
    if_instr = '0;
    if_pc    = '0;
    flush    = 1'b0;
    ex_ready = 1'b1;

    @(negedge clk);
    chk("rst_if_ready", 32'(if_ready), 32'd0);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_instr", id_instr, 32'h0000_0013);
    chk("rst_id_pc", id_pc, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_if_ready", 32'(if_ready), 32'd1);
    @(posedge clk);
    #1;

    // 1: independent addi stream, one issue per cycle
    send(ADDI1, 32'h100, 5'd0, 5'd1, 1'b0, 0, 1'b1, a0);
    send(ADDI2, 32'h104, 5'd1, 5'd2, 1'b0, 0, 1'b1, a1);
    send(ADDI3, 32'h108, 5'd2, 5'd3, 1'b0, 0, 1'b1, a2);
    chk("t1_no_gap", 32'(a2 - a0), 32'd2);
    chk("t1_no_gap_mid", 32'(a1 - a0), 32'd1);

    // 2: load-use, one bubble
    send(LW_X5, 32'h200, 5'd1, 5'd5, 1'b1, 0, 1'b1, acc);
    send(ADD_X5, 32'h204, 5'd5, 5'd6, 1'b0, 1, 1'b1, acc);
    @(negedge clk);
    chk("t2_bubble_valid", 32'(id_valid), 32'd0);
    chk("t2_bubble_if_ready", 32'(if_ready), 32'd0);
    chk("t2_bubble_held", id_instr, ADD_X5);
    @(posedge clk);
    #1;

    // 3: load to x0, and lui not reading rs1: no bubble
    send(LW_X0, 32'h300, 5'd1, 5'd0, 1'b1, 0, 1'b1, acc);
    send(ADD_X0, 32'h304, 5'd0, 5'd6, 1'b0, 0, 1'b1, acc);
    send(LW_X5, 32'h308, 5'd1, 5'd5, 1'b1, 0, 1'b1, acc);
    send(LUI_X5, 32'h30C, 5'd5, 5'd5, 1'b0, 0, 1'b1, acc);

    // 4: EX stalled for 3 cycles behind a load; dependent store waits
    send(LW_X5, 32'h400, 5'd1, 5'd5, 1'b1, 0, 1'b1, acc);
    send(SW_X5, 32'h404, 5'd2, 5'd0, 1'b0, 4, 1'b1, acc);
    ex_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", 32'(id_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    ex_ready = 1'b1;
    @(negedge clk);
    chk("t4_rise_valid", 32'(id_valid), 32'd0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;

    // 5: flush while FULL with a pending load hazard
    send(LW_X5, 32'h500, 5'd1, 5'd5, 1'b1, 0, 1'b1, acc);
    send(ADD_X5, 32'h504, 5'd5, 5'd6, 1'b0, 0, 1'b0, acc);
    flush    = 1'b1;
    if_valid = 1'b1;
    if_instr = ADDI1;
    if_pc    = 32'h508;
    ex_ready = 1'b0;
    @(negedge clk);
    chk("t5_flush_if_ready", 32'(if_ready), 32'd0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    if_valid = 1'b0;
    @(negedge clk);
    chk("t5_after_valid", 32'(id_valid), 32'd0);
    chk("t5_after_if_ready", 32'(if_ready), 32'd1);
    chk("t5_after_instr", id_instr, 32'h0000_0013);
    @(posedge clk);
    #1;
    send(ADD_X5, 32'h50C, 5'd5, 5'd6, 1'b0, 0, 1'b1, acc);
    ex_ready = 1'b1;
    @(posedge clk);
    #1;

    // 6: two load-use pairs after a fresh reset, then async reset mid-stream
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    send(LW_X5, 32'h600, 5'd1, 5'd5, 1'b1, 0, 1'b1, acc);
    send(ADD_X5, 32'h604, 5'd5, 5'd6, 1'b0, 1, 1'b1, acc);
    send(LW_X5, 32'h608, 5'd1, 5'd5, 1'b1, 0, 1'b1, acc);
    send(ADD_X5, 32'h60C, 5'd5, 5'd6, 1'b0, 1, 1'b1, acc);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
`ifdef STALL_CNT_EN
    chk("t6_stall_cycles", stall_cycles, 32'd2);
`endif
    send(ADDI1, 32'h610, 5'd0, 5'd1, 1'b0, 0, 1'b0, acc);
    chk("t6_pre_rst_valid", 32'(id_valid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(id_valid), 32'd0);
    chk("t6_rst_if_ready", 32'(if_ready), 32'd0);
    chk("t6_rst_instr", id_instr, 32'h0000_0013);
`ifdef STALL_CNT_EN
    chk("t6_rst_stall", stall_cycles, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decode_issue_ctrl.md
Name: decode_issue_ctrl

Overview:
Controls the IF/ID boundary of the 5-stage RV32I pipeline. Holds one fetched instruction in an ID holding register and extracts its register fields. Detects load-use hazards against the instruction last issued to EX, inserts one bubble per hazard, and issues to EX over a valid/ready handshake. Honours branch/jump flushes from EX.

Parameters:
XLEN, 32, width of instruction and PC
NOP_INSTR, 32'h00000013, value the ID register holds when empty or reset (addi x0,x0,0)

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-high reset
if_valid  in  1  fetch presents an instruction
if_instr  in  XLEN  fetched instruction
if_pc  in  XLEN  PC of fetched instruction
if_ready  out  1  ID register can accept this cycle
flush  in  1  EX redirect; kill ID contents
ex_ready  in  1  EX accepts an issued instruction
id_valid  out  1  issue request to EX
id_instr  out  XLEN  held instruction
id_pc  out  XLEN  held PC
id_rs1, id_rs2, id_rd  out  5  instr[19:15], [24:20], [11:7] of held instruction
id_opcode  out  7  instr[6:0]
id_is_load  out  1  id_opcode == 7'b0000011

Behaviour:
- One clock, rst asynchronous active-high. Everything is sampled on the rising clk edge.
- Reset values: full=0, id_instr=NOP_INSTR, id_pc=0, last_load_v=0, last_load_rd=0, id_valid=0. if_ready is 0 while rst is high.
- State: 1-bit full (EMPTY/FULL), plus last_load_v and last_load_rd[4:0]. Derived condition STALL = FULL && hazard.
- uses_rs1 = opcode not in {0110111 LUI, 0010111 AUIPC, 1101111 JAL}.
- uses_rs2 = opcode in {0110011 R, 0100011 S, 1100011 B}.
- hazard = full && last_load_v && last_load_rd!=0 && ((uses_rs1 && rs1==last_load_rd) || (uses_rs2 && rs2==last_load_rd)).
- id_valid = full && !hazard (combinational). id_fire = id_valid && ex_ready.
- if_ready = !rst && !flush && (!full || id_fire). if_fire = if_valid && if_ready.
- On if_fire: the ID register loads instr and pc, and full=1.
- On id_fire without if_fire: full=0 and id_instr=NOP_INSTR.
- last_load tracker updates only when ex_ready=1: last_load_v <= id_fire && id_is_load; last_load_rd <= id_rd. When ex_ready=0 the tracker holds, so the hazard persists until EX advances. Result: exactly one bubble per dependent load when EX is not stalled.
- Latency: instruction accepted in cycle N is issuable in cycle N+1. Throughput is 1/cycle with no hazard.
- flush has highest priority in its cycle. full<=0, id_instr<=NOP_INSTR, last_load_v<=0. id_valid may still be high in the flush cycle; EX discards it.
- Simultaneous if_fire and id_fire: the new instruction replaces the old one, and full stays 1.
- A load with rd=x0 never causes a stall.
- rst asserted mid-operation: all state clears immediately (async). The in-flight instruction is lost.

Optional Feature:
STALL_CNT_EN.
- Defined: adds output stall_cycles[31:0]. Reset 0. Increments each cycle where full && hazard. Saturates at 32'hFFFFFFFF. Clears on rst only, not on flush.
- Undefined: the port and counter are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package riscv_pkg: opcode constants (OP_LOAD, OP_STORE, OP_BRANCH, OP_RTYPE, OP_LUI, OP_AUIPC, OP_JAL), NOP_INSTR, REG_ADDR_W=5.
- One natural combinational sub-module, hazard_detect. Inputs: opcode, rs1, rs2, last_load_v, last_load_rd. Outputs: uses_rs1, uses_rs2, hazard.

Test Plan:
1. Reset, then stream of three independent addi with ex_ready=1 -> if_ready=1; id_valid high one cycle after each accept; id_rs1/id_rd match instruction fields; no gaps.
2. lw x5,0(x1) then add x6,x5,x2 -> add held with id_valid=0 for exactly one cycle, issues the next cycle; if_ready=0 during the bubble.
3. lw x0,0(x1) then add x6,x0,x2 -> no bubble. Separately: lw x5 then lui x5 -> no bubble (rs1 unused).
4. lw x5 issued, ex_ready=0 for 3 cycles, dependent sw x5,0(x2) held -> id_valid=0 until one cycle after ex_ready rises.
5. flush asserted while FULL, with if_valid=1 -> next cycle full=0, id_instr=32'h00000013, if_ready=0 in the flush cycle, pending load hazard cleared.
6. (STALL_CNT_EN) two load-use pairs with ex_ready=1 -> stall_cycles=2. Async rst mid-stream -> stall_cycles=0 and id_valid=0 immediately, without waiting for a clock edge.
